// File: rtl/eq_sched_pkg.sv
// eq_sched_pkg: shared FSM state type and default band count for the equalizer band scheduler.
package eq_sched_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, RUN, DRAIN} sched_state_t;
  localparam int NUM_BANDS_DEF = 5;
endpackage

// File: rtl/eq_band_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module rr_arbiter #(
  parameter int N = 5,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_vld
);
  logic [2*N-1:0] dbl;
  // Lower copy masked below ptr, upper copy unmasked, so the lowest set bit wraps naturally.
  always_comb begin
    dbl = {req, req} & ({2*N{1'b1}} << ptr);
    gnt_vld = |req;
    gnt_idx = '0;
    for (int i = 2*N-1; i >= 0; i--) if (dbl[i]) gnt_idx = W'(i >= N ? i - N : i);
  end
endmodule

// File: rtl/eq_band_scheduler.sv
// eq_band_scheduler: round-robin sharing of one FIR MAC engine between equalizer band queues.
// Optional grant timeout with sticky err when EQ_SCHED_TIMEOUT_EN is defined.
module eq_band_scheduler
  import eq_sched_pkg::*;
#(
  parameter int NUM_BANDS   = NUM_BANDS_DEF,
  parameter int TIMEOUT_CYC = 2048
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_BANDS-1:0]         band_req,
  input  logic [NUM_BANDS-1:0]         band_done,
  output logic [NUM_BANDS-1:0]         band_start,
  output logic [$clog2(NUM_BANDS)-1:0] band_sel,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         overrun,
  output logic                         err
);
  localparam int W = $clog2(NUM_BANDS);
  sched_state_t state_q, state_d;
  logic [NUM_BANDS-1:0] pending_q, pending_d, clr;
  logic [W-1:0] ptr_q, ptr_d, sel_q, sel_d, gnt_idx;
  logic busy_q, busy_d, overrun_q, overrun_d, gnt_vld, fin, tmo;

  rr_arbiter #(.N(NUM_BANDS), .W(W)) u_arb (
    .req(pending_q), .ptr(ptr_q), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld)
  );

`ifdef EQ_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC+1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  assign tmo = state_q == RUN && !band_done[sel_q] && cnt_q == CW'(TIMEOUT_CYC-1);
  always_comb begin
    cnt_d = state_q == GRANT ? '0 : state_q == RUN ? cnt_q + 1'b1 : cnt_q;
    err_d = err_q | tmo;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  assign err = err_q;
`else
  assign tmo = 1'b0;
  // Timeout disabled: err is constant 0 for any legal TIMEOUT_CYC.
  assign err = TIMEOUT_CYC < 0;
`endif

  always_comb begin
    fin       = state_q == RUN && (band_done[sel_q] || tmo);
    clr       = fin ? NUM_BANDS'(1) << sel_q : '0;
    pending_d = (pending_q & ~clr) | band_req;
    overrun_d = |(band_req & pending_q & ~clr);
    ptr_d     = fin ? (sel_q == W'(NUM_BANDS-1) ? '0 : sel_q + 1'b1) : ptr_q;
    state_d   = state_q == GRANT ? RUN :
                state_q == RUN   ? (fin ? DRAIN : RUN) :
                gnt_vld          ? GRANT : IDLE;
    sel_d     = state_d == GRANT ? gnt_idx : sel_q;
    busy_d    = state_d == GRANT || state_d == RUN;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      ptr_q     <= '0;
      sel_q     <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end

  assign band_start = state_q == GRANT ? NUM_BANDS'(1) << sel_q : '0;
  assign frame_done = state_q == DRAIN && !gnt_vld;
  assign band_sel   = sel_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_eq_band_scheduler.sv
// tb_eq_band_scheduler: directed checks of grant order, latency, overrun, re-serve, frame_done and timeout.
module tb_eq_band_scheduler;
  logic clk = 0, rst_n = 0;
  logic [4:0] band_req = '0, band_done = '0, band_start;
  logic [2:0] band_sel;
  logic busy, frame_done, overrun, err;
  int checks = 0, errors = 0, fds = 0, ovs = 0, dn_cnt = 0, dn_sel = 0, f0, o0;
  bit auto_done = 1;
  int starts[$];

  eq_band_scheduler #(.NUM_BANDS(5), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .band_req(band_req), .band_done(band_done),
    .band_start(band_start), .band_sel(band_sel), .busy(busy),
    .frame_done(frame_done), .overrun(overrun), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    band_done = '0;
    if (dn_cnt > 0) begin
      dn_cnt--;
      if (dn_cnt == 0 && auto_done) band_done = 5'(1) << dn_sel;
    end
    if (band_start != 0) begin
      starts.push_back(int'(band_sel));
      dn_cnt = 4;
      dn_sel = int'(band_sel);
    end
    if (frame_done) fds++;
    if (overrun) ovs++;
  endtask

  task automatic pulse_req(input logic [4:0] v);
    band_req = v;
    tick();
    band_req = '0;
  endtask

  task automatic wait_frame(input int max);
    int f = fds;
    for (int i = 0; i < max && fds == f; i++) tick();
    chk("frame_seen", fds - f, 1);
  endtask

  function automatic int packed_starts();
    int p = 0;
    foreach (starts[i]) p = p * 16 + starts[i] + 1;
    return p;
  endfunction

  task automatic do_reset();
    rst_n = 0;
    dn_cnt = 0;
    band_req = '0;
    tick();
    rst_n = 1;
    tick();
    starts.delete();
  endtask

  initial begin
    band_req = 5'b00100;
    repeat (3) tick();
    chk("rst_start", band_start, 5'b0);
    chk("rst_sel", band_sel, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame", frame_done, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_err", err, 1'b0);
    rst_n = 1;
    tick();
    chk("lat_no_start", band_start, 5'b0);
    band_req = '0;
    tick();
    chk("lat_start", band_start, 5'b00100);
    chk("lat_sel", band_sel, 3'd2);
    chk("lat_busy", busy, 1'b1);
    wait_frame(20);
    chk("t1_order", packed_starts(), 'h3);
    starts.delete();
    pulse_req(5'b00101);
    wait_frame(40);
    chk("wrap_order", packed_starts(), 'h13);
    do_reset();
    f0 = fds;
    pulse_req(5'b10011);
    wait_frame(60);
    repeat (10) tick();
    chk("rr_order", packed_starts(), 'h125);
    chk("one_frame", fds - f0, 1);
    chk("idle_busy", busy, 1'b0);
    starts.delete();
    o0 = ovs;
    pulse_req(5'b00010);
    pulse_req(5'b00010);
    chk("overrun_pulse", overrun, 1'b1);
    tick();
    chk("overrun_clear", overrun, 1'b0);
    band_done = 5'b00001;
    tick();
    chk("foreign_done", busy, 1'b1);
    wait_frame(20);
    chk("ovr_once", packed_starts(), 'h2);
    chk("ovr_count", ovs - o0, 1);
    starts.delete();
    f0 = fds;
    auto_done = 0;
    pulse_req(5'b01000);
    tick();
    chk("b3_start", band_start, 5'b01000);
    tick();
    tick();
    band_done = 5'b01000;
    band_req = 5'b01000;
    tick();
    band_req = '0;
    chk("reserve_no_ovr", overrun, 1'b0);
    chk("reserve_no_frame", frame_done, 1'b0);
    chk("drain_busy", busy, 1'b0);
    tick();
    chk("b3_again", band_start, 5'b01000);
    auto_done = 1;
    wait_frame(20);
    chk("reserve_order", packed_starts(), 'h44);
    chk("reserve_frames", fds - f0, 1);
`ifdef EQ_SCHED_TIMEOUT_EN
    do_reset();
    auto_done = 0;
    pulse_req(5'b00011);
    tick();
    chk("to_start0", band_start, 5'b00001);
    repeat (16) tick();
    chk("to_err_pre", err, 1'b0);
    tick();
    chk("to_err", err, 1'b1);
    chk("to_busy", busy, 1'b0);
    tick();
    chk("to_next", band_start, 5'b00010);
    auto_done = 1;
    wait_frame(20);
    chk("to_order", packed_starts(), 'h12);
    chk("to_sticky", err, 1'b1);
    do_reset();
    chk("to_err_rst", err, 1'b0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
